// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : 32-entry register file with write-first bypass and a 2-bit
//                pending-write scoreboard that raises stall on RAW/overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int WORD    = 32,
    parameter int REG_LOG = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               wb_we,
    input  logic [REG_LOG-1:0] wb_rd,
    input  logic [WORD-1:0]    wb_data,
    input  logic [REG_LOG-1:0] rj_addr,
    input  logic [REG_LOG-1:0] rk_addr,
    input  logic               rj_used,
    input  logic               rk_used,
    input  logic               issue_valid,
    input  logic               issue_we,
    input  logic [REG_LOG-1:0] issue_rd,
    input  logic               flush,
    output logic [WORD-1:0]    rj_data,
    output logic [WORD-1:0]    rk_data,
    output logic               stall
);
    localparam int NREG = 1 << REG_LOG;

    logic [WORD-1:0]      regs_q [NREG];
    logic [NREG-1:0][1:0] cnt_q;
    logic [NREG-1:0][1:0] cnt_d;
    logic [NREG-1:0]      w_dec;
    logic [NREG-1:0]      w_eb;
    logic                 w_wb_hit;
    logic                 w_fire;
    logic                 w_full_stall;

    assign w_wb_hit = wb_we & (wb_rd != '0);

    // Write-first read ports: a same-cycle writeback wins over stored data.
    assign rj_data = (rj_addr == '0) ? '0 :
                     (w_wb_hit & (wb_rd == rj_addr)) ? wb_data : regs_q[rj_addr];
    assign rk_data = (rk_addr == '0) ? '0 :
                     (w_wb_hit & (wb_rd == rk_addr)) ? wb_data : regs_q[rk_addr];

    // A fourth outstanding write only fits if one retires in the same cycle.
    assign w_full_stall = issue_we & (issue_rd != '0) &
                          (cnt_q[issue_rd] == 2'd3) & ~w_dec[issue_rd];

    assign stall = issue_valid & ((rj_used & w_eb[rj_addr]) |
                                  (rk_used & w_eb[rk_addr]) |
                                  w_full_stall);

    assign w_fire = issue_valid & ~stall;

    assign w_dec[0] = 1'b0;
    assign w_eb[0]  = 1'b0;
    assign cnt_d[0] = 2'd0;

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        logic w_inc;

        assign w_dec[g] = wb_we & (wb_rd == REG_LOG'(g));
        assign w_inc    = w_fire & issue_we & (issue_rd == REG_LOG'(g));
        // Retiring the last pending write is covered by the bypass path.
        assign w_eb[g]  = (cnt_q[g] > 2'd1) | ((cnt_q[g] == 2'd1) & ~w_dec[g]);

        assign cnt_d[g] = flush                                    ? 2'd0 :
                          (w_inc & ~w_dec[g])                      ? cnt_q[g] + 2'd1 :
                          (w_dec[g] & ~w_inc & (cnt_q[g] != 2'd0)) ? cnt_q[g] - 2'd1 :
                                                                     cnt_q[g];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (w_wb_hit) begin
                regs_q[wb_rd] <= wb_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Directed vector table plus randomized traffic checked against
//                an array/counter reference model of the register scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rstn;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rj_addr, rk_addr;
    logic        rj_used, rk_used;
    logic        issue_valid, issue_we;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [31:0] rj_data, rk_data;
    logic        stall;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_mem [32];
    int          m_cnt [32];

    typedef struct {
        string       name;
        bit          we;
        int          rd;
        logic [31:0] d;
        int          rj;
        bit          ju;
        int          rk;
        bit          ku;
        bit          iv;
        bit          iwe;
        int          ird;
        bit          fl;
        bit          es;
        logic [31:0] ej;
        logic [31:0] ek;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    regfile_scoreboard #(.WORD(32), .REG_LOG(5)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .rj_addr     (rj_addr),
        .rk_addr     (rk_addr),
        .rj_used     (rj_used),
        .rk_used     (rk_used),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .rj_data     (rj_data),
        .rk_data     (rk_data),
        .stall       (stall)
    );

    function automatic vec_t mk(string n, int we, int rd, logic [31:0] d,
                                int rj, int ju, int rk, int ku,
                                int iv, int iwe, int ird, int fl,
                                int es, logic [31:0] ej, logic [31:0] ek);
        vec_t v;
        v.name = n;   v.we = (we != 0);   v.rd = rd;   v.d = d;
        v.rj = rj;    v.ju = (ju != 0);   v.rk = rk;   v.ku = (ku != 0);
        v.iv = (iv != 0);  v.iwe = (iwe != 0);  v.ird = ird;  v.fl = (fl != 0);
        v.es = (es != 0);  v.ej = ej;  v.ek = ek;
        return v;
    endfunction

    // Reference model: plain array of values and integer pending counts.
    function automatic void m_clear();
        for (int r = 0; r < 32; r++) begin
            m_mem[r] = 32'h0;
            m_cnt[r] = 0;
        end
    endfunction

    function automatic bit m_busy(int r);
        bit retiring;
        retiring = wb_we && (int'(wb_rd) == r) && (r != 0);
        return (m_cnt[r] > 1) || (m_cnt[r] == 1 && !retiring);
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_we && wb_rd == a) return wb_data;
        return m_mem[a];
    endfunction

    function automatic bit m_stall();
        bit full;
        if (!issue_valid) return 1'b0;
        full = issue_we && (issue_rd != 5'd0) && (m_cnt[issue_rd] == 3) &&
               !(wb_we && wb_rd == issue_rd);
        return (rj_used && m_busy(int'(rj_addr))) ||
               (rk_used && m_busy(int'(rk_addr))) || full;
    endfunction

    function automatic void m_commit();
        bit fire;
        int delta;
        fire = issue_valid && !m_stall();
        if (wb_we && wb_rd != 5'd0) m_mem[wb_rd] = wb_data;
        for (int r = 1; r < 32; r++) begin
            if (flush) begin
                m_cnt[r] = 0;
            end else begin
                delta = 0;
                if (fire && issue_we && int'(issue_rd) == r) delta = delta + 1;
                if (wb_we && int'(wb_rd) == r) delta = delta - 1;
                m_cnt[r] = m_cnt[r] + delta;
                if (m_cnt[r] < 0) m_cnt[r] = 0;
            end
        end
    endfunction

    task automatic check(string name, bit es, logic [31:0] ej, logic [31:0] ek);
        n_vec++;
        if (stall !== es || rj_data !== ej || rk_data !== ek) begin
            n_err++;
            $display("FAIL %s: got stall=%0b rj=%h rk=%h, expected stall=%0b rj=%h rk=%h",
                     name, stall, rj_data, rk_data, es, ej, ek);
        end
    endtask

    task automatic drive(vec_t v);
        wb_we       = v.we;
        wb_rd       = 5'(v.rd);
        wb_data     = v.d;
        rj_addr     = 5'(v.rj);
        rj_used     = v.ju;
        rk_addr     = 5'(v.rk);
        rk_used     = v.ku;
        issue_valid = v.iv;
        issue_we    = v.iwe;
        issue_rd    = 5'(v.ird);
        flush       = v.fl;
    endtask

    task automatic run_vec(vec_t v);
        drive(v);
        @(negedge clk);
        check(v.name, v.es, v.ej, v.ek);
        m_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rand();
        bit wide;
        wide        = ($urandom_range(0, 7) == 0);
        wb_we       = ($urandom_range(0, 9) < 4);
        wb_rd       = 5'($urandom_range(0, wide ? 31 : 7));
        wb_data     = $urandom;
        rj_addr     = 5'($urandom_range(0, wide ? 31 : 7));
        rk_addr     = 5'($urandom_range(0, 7));
        rj_used     = ($urandom_range(0, 9) < 6);
        rk_used     = ($urandom_range(0, 9) < 6);
        issue_valid = ($urandom_range(0, 9) < 7);
        issue_we    = ($urandom_range(0, 9) < 6);
        issue_rd    = 5'($urandom_range(0, 7));
        flush       = ($urandom_range(0, 31) == 0);
        @(negedge clk);
        check("rand", m_stall(), m_read(rj_addr), m_read(rk_addr));
        m_commit();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        drive(mk("idle", 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
        m_clear();

        // Outputs while reset is held: bypass still works, counters read empty.
        #2;
        drive(mk("rst", 1,4,32'h44, 4,1,5,0, 1,1,1,0, 0,0,0));
        #1;
        check("rst_outputs", 1'b0, 32'h44, 32'h0);
        @(posedge clk);
        drive(mk("idle", 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back(mk("rst_rd_r5_r31",     0,0,0,            5,0,31,0, 0,0,0,0, 0,0,0));
        tbl.push_back(mk("wb_r0",             1,0,32'hDEADBEEF, 0,0,0,0,  0,0,0,0, 0,0,0));
        tbl.push_back(mk("rd_r0",             0,0,0,            0,1,5,0,  0,0,0,0, 0,0,0));
        tbl.push_back(mk("iss_r3",            0,0,0,            3,0,0,0,  1,1,3,0, 0,0,0));
        tbl.push_back(mk("rd_r3_busy",        0,0,0,            3,1,0,0,  1,0,0,0, 1,0,0));
        tbl.push_back(mk("wb_r3_bypass",      1,3,32'h1234,     3,1,0,0,  1,0,0,0, 0,32'h1234,0));
        tbl.push_back(mk("rd_r3_free",        0,0,0,            3,1,0,0,  1,0,0,0, 0,32'h1234,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("iss_r7",        0,0,0,            0,0,0,0,  1,1,7,0, 0,0,0));
        tbl.push_back(mk("iss_r7_full",       0,0,0,            0,0,7,0,  1,1,7,0, 1,0,0));
        tbl.push_back(mk("iss_r7_wb",         1,7,32'h77,       0,0,7,0,  1,1,7,0, 0,0,32'h77));
        tbl.push_back(mk("iss_r7_still_full", 0,0,0,            0,0,7,0,  1,1,7,0, 1,0,32'h77));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("drain_r7",      1,7,32'h71 + i,   0,0,7,0,  0,0,0,0, 0,0,32'h71 + i));
        tbl.push_back(mk("rd_r7_free",        0,0,0,            0,0,7,1,  1,0,0,0, 0,0,32'h73));
        tbl.push_back(mk("iss_r9",            0,0,0,            0,0,0,0,  1,1,9,0, 0,0,0));
        tbl.push_back(mk("iss_wb_r9",         1,9,32'h99,       9,0,0,0,  1,1,9,0, 0,32'h99,0));
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk("rd_r9_busy",    0,0,0,            9,1,0,0,  1,0,0,0, 1,32'h99,0));
        tbl.push_back(mk("rd_r9_wb",          1,9,32'h9A,       9,1,0,0,  1,0,0,0, 0,32'h9A,0));
        tbl.push_back(mk("iss_r2",            0,0,0,            0,0,0,0,  1,1,2,0, 0,0,0));
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk("iss_r4",        0,0,0,            0,0,0,0,  1,1,4,0, 0,0,0));
        tbl.push_back(mk("flush_wb_r2",       1,2,32'h55,       2,0,4,0,  0,0,0,1, 0,32'h55,0));
        tbl.push_back(mk("rd_r2_r4_free",     0,0,0,            2,1,4,1,  1,0,0,0, 0,32'h55,0));
        tbl.push_back(mk("wb_r5_idle",        1,5,32'hA5,       5,0,0,0,  0,0,0,0, 0,32'hA5,0));
        tbl.push_back(mk("iss_r5_no_uflow",   0,0,0,            5,1,0,0,  1,1,5,0, 0,32'hA5,0));
        tbl.push_back(mk("rd_r5_busy",        0,0,0,            5,1,0,0,  1,0,0,0, 1,32'hA5,0));
        tbl.push_back(mk("wb_r5_retire",      1,5,32'hA6,       5,1,0,0,  1,0,0,0, 0,32'hA6,0));
        tbl.push_back(mk("iss_r6",            0,0,0,            0,0,0,0,  1,1,6,0, 0,0,0));
        tbl.push_back(mk("iss_r6",            0,0,0,            0,0,0,0,  1,1,6,0, 0,0,0));

        foreach (tbl[i]) run_vec(tbl[i]);

        // Asynchronous reset between edges with two writes pending on r6.
        drive(mk("rd_r6", 0,0,0, 6,1,2,1, 1,0,0,0, 0,0,0));
        #1;
        check("pre_async_rst", 1'b1, 32'h0, 32'h55);
        #1 rstn = 1'b0;
        #1;
        check("async_rst", 1'b0, 32'h0, 32'h0);
        m_clear();
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        run_vec(mk("rd_r6_after_rst", 0,0,0, 6,1,2,1, 1,0,0,0, 0,0,0));

        for (int i = 0; i < 400; i++) run_rand();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter: WORD, 32, data width; REG_LOG, 5, register address width; 32 architectural registers.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 wb_we  input  1  writeback enable from WB stage.
REQ-005 wb_rd  input  REG_LOG  writeback destination register.
REQ-006 wb_data  input  WORD  writeback data.
REQ-007 rj_addr, rk_addr  input  REG_LOG each  decode-stage source register addresses.
REQ-008 rj_used, rk_used  input  1 each  source operand actually consumed by the decoding instruction.
REQ-009 issue_valid  input  1  decode-stage instruction wants to issue.
REQ-010 issue_we, issue_rd  input  1, REG_LOG  issuing instruction writes issue_rd.
REQ-011 flush  input  1  pipeline squash; no older writeback outstanding when asserted.
REQ-012 rj_data, rk_data  output  WORD each  source operand values.
REQ-013 stall  output  1  decode must hold; instruction not issued this cycle.

Function
REQ-014 Storage SHALL be 32 x WORD registers; register 0 SHALL always read 0 and never be written.
REQ-015 A write SHALL occur on the rising edge when wb_we=1 and wb_rd!=0.
REQ-016 Read ports SHALL be combinational; address 0 -> 0.
REQ-017 Bypass: if wb_we=1, wb_rd!=0, and wb_rd equals a read address in the same cycle, that port SHALL return wb_data (write-first).
REQ-018 Each register 1..31 SHALL have a 2-bit pending-write counter cnt[r] (0..3); cnt[0] SHALL be constantly 0.
REQ-019 issue_fire SHALL be issue_valid & ~stall.
REQ-020 inc[r] = issue_fire & issue_we & (issue_rd==r); dec[r] = wb_we & (wb_rd==r); for r!=0.
REQ-021 Next-state: inc&~dec -> cnt+1; dec&~inc -> cnt-1; both or neither -> unchanged.
REQ-022 dec while cnt==0 SHALL leave cnt at 0, with no underflow; the write still commits.
REQ-023 Effective busy eb[r] SHALL be (cnt[r]>1) | (cnt[r]==1 & ~dec[r]); a register retiring its last pending write this cycle is not busy, because the bypass covers it.
REQ-024 stall SHALL be issue_valid & ((rj_used & eb[rj_addr]) | (rk_used & eb[rk_addr]) | (issue_we & issue_rd!=0 & cnt[issue_rd]==3 & ~dec[issue_rd])).
REQ-025 stall SHALL be 0 when issue_valid=0.
REQ-026 flush=1 SHALL clear all counters on the next edge, overriding inc and dec; a same-cycle WB write SHALL still commit to storage.
REQ-027 stall SHALL be purely combinational from the current inputs and counter state, with no cycle of latency; a write is visible to storage reads one cycle after its edge, and to the bypass in the same cycle.

Reset
REQ-028 rstn=0 SHALL asynchronously clear all 32 data registers to 0 and all counters to 0.
REQ-029 During reset the outputs SHALL be: rj_data=rk_data=0 unless bypassed; stall follows REQ-024 with all counters 0, so only reset-time inputs can drive it.
REQ-030 Reset asserted mid-operation SHALL discard all pending counts and data; the first edge after release SHALL behave as from an empty state.

Verification
REQ-031 Reset, then read r5/r31 -> 0; write r0=0xDEADBEEF, then read r0 -> 0.
REQ-032 Issue write r3 (cnt 0->1); next cycle a reader of r3 -> stall=1; WB r3=0x1234 the same cycle as a reader of r3 -> stall=0, rj_data=0x1234 (bypass), cnt 0.
REQ-033 Issue three writes to r7 back-to-back -> cnt=3; fourth write to r7 with no WB -> stall=1; same request with a WB of r7 that cycle -> stall=0, cnt stays 3.
REQ-034 Issue write r9 and WB r9 in the same cycle with cnt[r9]=1 -> cnt[r9] remains 1; a following reader stalls until the next WB of r9.
REQ-035 Pending counts on r2 and r4, then flush=1 together with WB r2=0x55 -> all cnt 0, r2 reads 0x55, no stall on readers of r4.
REQ-036 Assert rstn=0 asynchronously between edges with cnt[r6]=2 -> counters and data clear immediately; after release, a reader of r6 -> stall=0, data 0.
